sync_frame_tx: RTL and testbench
================================

Name: sync_frame_tx

Overview:
Serial frame transmitter that produces the bit stream a sync-word detector consumes. Each frame is a fixed sync word, MSB first, followed by a parallel payload word serialised MSB first, followed by a forced idle gap. Payload words are loaded through a valid/ready handshake. The block sits between a word-level producer and a 1-bit serial link.

Parameters:
SYNC_W, 4, sync word width in bits (>=1)
SYNC, 4'b1011, sync word value, transmitted MSB first
DATA_W, 8, payload width in bits (>=1)
GAP_CYCLES, 2, idle-0 cycles after each frame (>=1)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-low (asserted when 0, sampled on posedge clk)
load_valid  input  1  producer has a payload word
load_data  input  DATA_W  payload word
load_ready  output  1  block can accept a word (high only in IDLE)
data_out  output  1  registered serial bit
frame_active  output  1  high while a sync or payload bit is on data_out
frame_done  output  1  one-cycle pulse coincident with the last payload bit on data_out

Behaviour:
- Reset (rst==0 at posedge): state=IDLE, data_out=0, frame_active=0, frame_done=0, load_ready=1, bit counter=0, payload register=0. Reset overrides everything, including mid-frame; a partial frame is abandoned with no completion pulse.
- All outputs are registered, except load_ready, which is decoded from state (state==IDLE).
- States: IDLE, SYNC, DATA, GAP.
- IDLE: data_out=0. On posedge with load_valid&&load_ready, capture load_data and go to SYNC. data_out=SYNC[SYNC_W-1] and frame_active=1 from that same edge.
- SYNC: emits SYNC[SYNC_W-1] down to SYNC[0], one bit per cycle. After SYNC_W bits go to DATA. The first payload bit is data[DATA_W-1].
- DATA: emits the payload MSB first via a left shift, one bit per cycle, DATA_W cycles. frame_done=1 during the cycle data[0] is on data_out. Next edge goes to GAP with data_out=0 and frame_active=0.
- GAP: data_out=0 for exactly GAP_CYCLES cycles, then go to IDLE.
- Latency and occupancy:
  - Handshake at edge k: first sync bit visible after edge k.
  - Last payload bit visible after edge k+SYNC_W+DATA_W-1.
  - load_ready low for SYNC_W+DATA_W+GAP_CYCLES cycles.
  - Maximum throughput: one frame per SYNC_W+DATA_W+GAP_CYCLES+1 cycles.
- load_valid while load_ready=0 is ignored; the producer must hold the word. load_data changes outside the handshake edge have no effect on the frame in flight.
- Bit counter width: $clog2(max(SYNC_W,DATA_W,GAP_CYCLES)+1). It counts down and reloads at each state entry. There is no wrap-around within a state.
- Payload content is not checked. Sync emulation inside the payload is the consumer's concern.
- No illegal state is reachable. The default branch returns to IDLE with outputs cleared.

Decomposition:
- Shared package: state encoding enum (IDLE/SYNC/DATA/GAP, 2 bits), default SYNC pattern constant 4'b1011, clog2 helper.
- One natural sub-module: piso_shift, a parallel-load MSB-first shift register with load and shift enables. It is used for the payload; the sync bits are indexed directly from the parameter.

Test Plan:
- Defaults, load 8'hA5 once: data_out = 1,0,1,1,1,0,1,0,0,1,0,1 then 0,0. frame_done only on the 12th bit. load_ready low 14 cycles, then high.
- load_valid held high with 8'h00 then 8'hFF: frames are back-to-back with exactly 2 zero gap cycles plus 1 IDLE cycle between them. Payload bits are all 0, then all 1. Each frame has exactly one frame_done.
- Change load_data and pulse load_valid mid-frame: transmitted bits still match the originally accepted word, and no extra frame is sent.
- Assert rst=0 during the 3rd payload bit: next edge data_out=0, frame_active=0, load_ready=1, no frame_done. The next load transmits a full fresh frame.
- Apply load_valid in the same cycle rst=0: word not accepted, block stays IDLE after reset releases.
- SYNC_W=6, SYNC=6'b110101, DATA_W=3, GAP_CYCLES=1, load 3'b011: data_out = 1,1,0,1,0,1,0,1,1,0, and busy for 10 cycles.

Source files
------------

// File: rtl/sync_frame_tx_pkg.sv
// Shared types and helpers for the sync-word frame transmitter.
package sync_frame_tx_pkg;

  // Transmitter phases: waiting for a word, sync word, payload, idle gap.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_DATA = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  // Default sync pattern, sent MSB first at the head of every frame.
  localparam logic [3:0] DEFAULT_SYNC = 4'b1011;

  // Number of bits needed to hold values 0 .. value-1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

  // Largest of three integers, used to size the shared bit counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/sync_frame_tx_piso_shift.sv
// Parallel-in serial-out shift register, MSB first. Holds the payload word
// while the frame is in flight so later changes on the input bus are ignored.
module piso_shift #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         msb
);

  logic [W-1:0] sh_q;

  // Capture a new word on load, otherwise move the next bit into the MSB slot.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sh_q <= '0;
    end else if (load) begin
      sh_q <= din;
    end else if (shift) begin
      sh_q <= sh_q << 1;
    end
  end

  assign msb = sh_q[W-1];

endmodule

// File: rtl/sync_frame_tx.sv
// Serial frame transmitter: sync word, then payload (both MSB first), then a
// forced run of idle zeros. Words arrive over a valid/ready handshake that is
// only open while the transmitter is idle.
module sync_frame_tx
  import sync_frame_tx_pkg::*;
#(
  parameter int                SYNC_W     = 4,
  parameter logic [SYNC_W-1:0] SYNC       = SYNC_W'(DEFAULT_SYNC),
  parameter int                DATA_W     = 8,
  parameter int                GAP_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic              data_out,
  output logic              frame_active,
  output logic              frame_done
);

  // One down-counter is shared by all phases, so it must hold the longest one.
  localparam int CNT_W = clog2(max3(SYNC_W, DATA_W, GAP_CYCLES) + 1);

  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t            state_q;
  state_t            state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              data_out_d;
  logic              frame_active_d;
  logic              frame_done_d;
  logic              load_en;
  logic              shift_en;
  logic              payload_msb;
  logic              sync_bit;
  logic              accept;

  // The handshake can only complete while idle; ready is a pure state decode.
  assign load_ready = (state_q == ST_IDLE);
  assign accept     = load_valid && load_ready;

  // In the sync phase the counter value is the index of the sync bit on the
  // line, so the next bit to show is selected by the next counter value.
  assign sync_bit = |(SYNC & (SYNC_W'(1) << cnt_d));

  piso_shift #(
    .W(DATA_W)
  ) u_payload (
    .clk   (clk),
    .rst   (rst),
    .load  (load_en),
    .shift (shift_en),
    .din   (load_data),
    .msb   (payload_msb)
  );

  // State, counter and all serial outputs are registered together.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      data_out     <= 1'b0;
      frame_active <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      data_out     <= data_out_d;
      frame_active <= frame_active_d;
      frame_done   <= frame_done_d;
    end
  end

  // Phase sequencing: each phase reloads the counter on entry and leaves when
  // the counter has run down to zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_SYNC;
          cnt_d   = SYNC_LAST;
        end
      end
      ST_SYNC: begin
        if (cnt_q == '0) begin
          state_d = ST_DATA;
          cnt_d   = DATA_LAST;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_DATA: begin
        if (cnt_q == '0) begin
          state_d = ST_GAP;
          cnt_d   = GAP_LAST;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Next values of the registered outputs plus payload register controls.
  always_comb begin
    data_out_d     = 1'b0;
    frame_active_d = 1'b0;
    frame_done_d   = 1'b0;
    load_en        = 1'b0;
    shift_en       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          load_en        = 1'b1;
          data_out_d     = sync_bit;
          frame_active_d = 1'b1;
        end
      end
      ST_SYNC: begin
        frame_active_d = 1'b1;
        if (cnt_q == '0) begin
          data_out_d   = payload_msb;
          shift_en     = 1'b1;
          frame_done_d = (DATA_W == 1);
        end else begin
          data_out_d = sync_bit;
        end
      end
      ST_DATA: begin
        if (cnt_q != '0) begin
          frame_active_d = 1'b1;
          data_out_d     = payload_msb;
          shift_en       = 1'b1;
          frame_done_d   = (cnt_q == CNT_ONE);
        end
      end
      ST_GAP: begin
        data_out_d = 1'b0;
      end
      default: begin
        data_out_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_sync_frame_tx.sv
// Self-checking bench for sync_frame_tx: a default instance and a 6/3/1
// variant, compared cycle by cycle against a frame-level stream model.
module tb_sync_frame_tx;

  typedef struct packed {
    logic d;
    logic a;
    logic f;
    logic r;
  } cyc_t;

  logic       clk;
  logic       rst;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_ready;
  logic       data_out;
  logic       frame_active;
  logic       frame_done;

  logic       load_valid2;
  logic [2:0] load_data2;
  logic       load_ready2;
  logic       data_out2;
  logic       frame_active2;
  logic       frame_done2;

  int   checks;
  int   errors;
  cyc_t exp_q[$];
  cyc_t got_q[$];

  sync_frame_tx dut (
    .clk          (clk),
    .rst          (rst),
    .load_valid   (load_valid),
    .load_data    (load_data),
    .load_ready   (load_ready),
    .data_out     (data_out),
    .frame_active (frame_active),
    .frame_done   (frame_done)
  );

  sync_frame_tx #(
    .SYNC_W     (6),
    .SYNC       (6'b110101),
    .DATA_W     (3),
    .GAP_CYCLES (1)
  ) dut2 (
    .clk          (clk),
    .rst          (rst),
    .load_valid   (load_valid2),
    .load_data    (load_data2),
    .load_ready   (load_ready2),
    .data_out     (data_out2),
    .frame_active (frame_active2),
    .frame_done   (frame_done2)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected per-cycle view of one frame: sync bits, payload bits, gap zeros.
  function automatic void model_frame(input int sw, input int dw, input int gw,
                                      input logic [31:0] sync, input logic [31:0] word);
    cyc_t c;
    for (int i = 0; i < sw; i++) begin
      c = '0; c.d = sync[sw-1-i]; c.a = 1'b1;
      exp_q.push_back(c);
    end
    for (int j = 0; j < dw; j++) begin
      c = '0; c.d = word[dw-1-j]; c.a = 1'b1; c.f = (j == dw - 1);
      exp_q.push_back(c);
    end
    for (int g = 0; g < gw; g++) begin
      c = '0;
      exp_q.push_back(c);
    end
  endfunction

  function automatic void model_idle(input int n);
    cyc_t c;
    for (int i = 0; i < n; i++) begin
      c = '0; c.r = 1'b1;
      exp_q.push_back(c);
    end
  endfunction

  // Records n cycles of the default instance; drops load_valid after sample clear_at.
  task automatic capture(input int n, input int clear_at);
    cyc_t c;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      c.d = data_out; c.a = frame_active; c.f = frame_done; c.r = load_ready;
      got_q.push_back(c);
      if (i == clear_at) load_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    load_valid = 1'b1; load_data = 8'($urandom);
    load_valid2 = 1'b1; load_data2 = 3'($urandom);
    repeat (3) @(negedge clk);
    checks++;
    if ({data_out, frame_active, frame_done, load_ready} !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL reset_state got dafr=%b want dafr=0001",
               {data_out, frame_active, frame_done, load_ready});
    end
    checks++;
    if ({data_out2, frame_active2, frame_done2, load_ready2} !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL reset_state2 got dafr=%b want dafr=0001",
               {data_out2, frame_active2, frame_done2, load_ready2});
    end
    rst = 1'b1; load_valid = 1'b0; load_valid2 = 1'b0;
    exp_q.delete(); got_q.delete();
    model_idle(3);
    capture(3, -1);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("[TB] FAIL reset_no_accept cycle %0d got dafr=%b want dafr=%b", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if ({frame_active2, load_ready2} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL reset_no_accept2 got ar=%b want ar=01", {frame_active2, load_ready2});
    end
  endtask

  task automatic test_single_frame();
    logic [7:0] w;
    int busy;
    int dones;
    for (int k = 0; k < 4; k++) begin
      w = (k == 0) ? 8'hA5 : 8'($urandom);
      exp_q.delete(); got_q.delete();
      load_valid = 1'b1; load_data = w;
      capture(15, 0);
      model_frame(4, 8, 2, 32'b1011, {24'd0, w});
      model_idle(1);
      busy = 0; dones = 0;
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++;
          $display("[TB] FAIL single_frame w=%h cycle %0d got dafr=%b want dafr=%b", w, i, got_q[i], exp_q[i]);
        end
        if (!got_q[i].r) busy++;
        if (got_q[i].f) dones++;
      end
      checks++;
      if (busy !== 14) begin
        errors++;
        $display("[TB] FAIL single_busy w=%h got %0d want 14", w, busy);
      end
      checks++;
      if (dones !== 1) begin
        errors++;
        $display("[TB] FAIL single_done_count w=%h got %0d want 1", w, dones);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] w0;
    logic [7:0] w1;
    int dones;
    for (int k = 0; k < 2; k++) begin
      w0 = (k == 0) ? 8'h00 : 8'($urandom);
      w1 = (k == 0) ? 8'hFF : 8'($urandom);
      exp_q.delete(); got_q.delete();
      load_valid = 1'b1; load_data = w0;
      capture(1, -1);
      load_data = w1;
      capture(29, 14);
      model_frame(4, 8, 2, 32'b1011, {24'd0, w0});
      model_idle(1);
      model_frame(4, 8, 2, 32'b1011, {24'd0, w1});
      model_idle(1);
      dones = 0;
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++;
          $display("[TB] FAIL back_to_back %h/%h cycle %0d got dafr=%b want dafr=%b",
                   w0, w1, i, got_q[i], exp_q[i]);
        end
        if (got_q[i].f) dones++;
      end
      checks++;
      if (dones !== 2) begin
        errors++;
        $display("[TB] FAIL back_to_back_done_count got %0d want 2", dones);
      end
    end
  endtask

  task automatic test_mid_frame_change();
    logic [7:0] w;
    cyc_t c;
    w = 8'($urandom);
    exp_q.delete(); got_q.delete();
    load_valid = 1'b1; load_data = w;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      c.d = data_out; c.a = frame_active; c.f = frame_done; c.r = load_ready;
      got_q.push_back(c);
      if (i == 0) begin
        load_valid = 1'b0; load_data = ~w;
      end else if (i >= 2 && i <= 10) begin
        load_valid = (i == 5) ? 1'b1 : 1'($urandom_range(0, 1));
        load_data = 8'($urandom);
      end else if (i == 11) begin
        load_valid = 1'b0;
      end
    end
    model_frame(4, 8, 2, 32'b1011, {24'd0, w});
    model_idle(2);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("[TB] FAIL mid_frame_change w=%h cycle %0d got dafr=%b want dafr=%b", w, i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] w;
    cyc_t c;
    w = 8'($urandom);
    exp_q.delete(); got_q.delete();
    load_valid = 1'b1; load_data = w;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      c.d = data_out; c.a = frame_active; c.f = frame_done; c.r = load_ready;
      got_q.push_back(c);
      if (i == 0) load_valid = 1'b0;
      if (i == 6) rst = 1'b0;
      if (i == 7) rst = 1'b1;
    end
    model_frame(4, 8, 2, 32'b1011, {24'd0, w});
    exp_q = exp_q[0:6];
    model_idle(2);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("[TB] FAIL reset_mid_frame cycle %0d got dafr=%b want dafr=%b", i, got_q[i], exp_q[i]);
      end
    end
    w = 8'($urandom);
    exp_q.delete(); got_q.delete();
    load_valid = 1'b1; load_data = w;
    capture(15, 0);
    model_frame(4, 8, 2, 32'b1011, {24'd0, w});
    model_idle(1);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("[TB] FAIL fresh_after_reset w=%h cycle %0d got dafr=%b want dafr=%b", w, i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_param_variant();
    logic [2:0] w;
    cyc_t c;
    int busy;
    for (int k = 0; k < 3; k++) begin
      w = (k == 0) ? 3'b011 : 3'($urandom);
      exp_q.delete(); got_q.delete();
      load_valid2 = 1'b1; load_data2 = w;
      for (int i = 0; i < 11; i++) begin
        @(negedge clk);
        c.d = data_out2; c.a = frame_active2; c.f = frame_done2; c.r = load_ready2;
        got_q.push_back(c);
        if (i == 0) load_valid2 = 1'b0;
      end
      model_frame(6, 3, 1, 32'b110101, {29'd0, w});
      model_idle(1);
      busy = 0;
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++;
          $display("[TB] FAIL param_variant w=%b cycle %0d got dafr=%b want dafr=%b", w, i, got_q[i], exp_q[i]);
        end
        if (!got_q[i].r) busy++;
      end
      checks++;
      if (busy !== 10) begin
        errors++;
        $display("[TB] FAIL param_busy w=%b got %0d want 10", w, busy);
      end
    end
  endtask

  // Runs every scenario in order and prints the summary.
  initial begin
    checks = 0; errors = 0;
    rst = 1'b0;
    load_valid = 1'b0; load_data = '0;
    load_valid2 = 1'b0; load_data2 = '0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_mid_frame_change();
    test_reset_mid_frame();
    test_param_variant();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

endmodule
